// File: rtl/station_sequencer.sv
// Station A/B sequencer: debounced station detect, one XADC temperature read and
// window judge at A, electromagnet hold from A to B, servo drop pulse at B.
module station_sequencer #(
    parameter int DEBOUNCE_CYC    = 3,
    parameter int SCALE           = 68,
    parameter int TEMP_LO         = 20,
    parameter int TEMP_HI         = 30,
    parameter int SERVO_HOLD_CYC  = 10,
    parameter int ADC_TIMEOUT_CYC = 8
) (
    input  logic        ACLK,
    input  logic        ARESET,
    input  logic        trigger,
    input  logic [11:0] digitalTemp,
    input  logic        ready,
    output logic        adcRequest,
    output logic        correct,
    output logic        controlEM,
    output logic        controlServo,
    output logic        busy,
    output logic        fault,
    output logic [3:0]  stationCount
);

    typedef enum logic [2:0] {
        WAIT_A, REQ, JUDGE, LEAVE_A, WAIT_B, SERVO, LEAVE_B
    } state_t;

    localparam logic [7:0]  DB_LAST    = 8'(DEBOUNCE_CYC - 1);
    localparam logic [7:0]  ADC_LAST   = 8'(ADC_TIMEOUT_CYC - 1);
    localparam logic [7:0]  SERVO_LAST = 8'(SERVO_HOLD_CYC - 1);
    localparam logic [12:0] WIN_LO     = 13'(TEMP_LO * SCALE);
    localparam logic [12:0] WIN_HI     = 13'(TEMP_HI * SCALE);

    state_t      state_q, state_d;
    logic [1:0]  sync_q, sync_d;
    logic        trig_db_q, trig_db_d;
    logic [7:0]  db_cnt_q, db_cnt_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [11:0] temp_q, temp_d;
    logic        correct_q, correct_d;
    logic        em_q, em_d;
    logic        fault_q, fault_d;
    logic [3:0]  station_q, station_d;
    logic        in_window;

    assign in_window = ({1'b0, temp_q} >= WIN_LO) && ({1'b0, temp_q} <= WIN_HI);

    always_comb begin
        state_d   = state_q;
        sync_d    = {sync_q[0], trigger};
        trig_db_d = trig_db_q;
        db_cnt_d  = 8'd0;
        cnt_d     = cnt_q;
        temp_d    = temp_q;
        correct_d = correct_q;
        em_d      = em_q;
        fault_d   = fault_q;
        station_d = station_q;

        // The run counter only advances while the synchronized input disagrees.
        if (sync_q[1] != trig_db_q) begin
            if (db_cnt_q == DB_LAST) begin
                trig_db_d = sync_q[1];
            end else begin
                db_cnt_d = db_cnt_q + 8'd1;
            end
        end

        case (state_q)
            WAIT_A: begin
                cnt_d = 8'd0;
                if (trig_db_q) state_d = REQ;
            end
            REQ: begin
                if (ready) begin
                    temp_d  = digitalTemp;
                    state_d = JUDGE;
                end else if (cnt_q == ADC_LAST) begin
                    fault_d   = 1'b1;
                    correct_d = 1'b0;
                    em_d      = 1'b0;
                    state_d   = LEAVE_A;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            JUDGE: begin
                correct_d = in_window;
                em_d      = in_window;
                state_d   = LEAVE_A;
            end
            LEAVE_A: begin
                if (!trig_db_q) state_d = WAIT_B;
            end
            WAIT_B: begin
                cnt_d = 8'd0;
                if (trig_db_q) begin
                    if (correct_q) begin
                        em_d    = 1'b0;
                        state_d = SERVO;
                    end else begin
                        state_d = LEAVE_B;
                    end
                end
            end
            SERVO: begin
                if (cnt_q == SERVO_LAST) begin
                    state_d = LEAVE_B;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            LEAVE_B: begin
                if (!trig_db_q) begin
                    station_d = station_q + 4'd1;
                    correct_d = 1'b0;
                    em_d      = 1'b0;
                    state_d   = WAIT_A;
                end
            end
            default: state_d = WAIT_A;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q   <= WAIT_A;
            sync_q    <= 2'b00;
            trig_db_q <= 1'b0;
            db_cnt_q  <= 8'd0;
            cnt_q     <= 8'd0;
            temp_q    <= 12'd0;
            correct_q <= 1'b0;
            em_q      <= 1'b0;
            fault_q   <= 1'b0;
            station_q <= 4'd0;
        end else begin
            state_q   <= state_d;
            sync_q    <= sync_d;
            trig_db_q <= trig_db_d;
            db_cnt_q  <= db_cnt_d;
            cnt_q     <= cnt_d;
            temp_q    <= temp_d;
            correct_q <= correct_d;
            em_q      <= em_d;
            fault_q   <= fault_d;
            station_q <= station_d;
        end
    end

    assign adcRequest   = (state_q == REQ);
    assign controlServo = (state_q == SERVO);
    assign busy         = (state_q != WAIT_A);
    assign correct      = correct_q;
    assign controlEM    = em_q;
    assign fault        = fault_q;
    assign stationCount = station_q;

endmodule

// File: tb/tb_station_sequencer.sv
// Directed bench for station_sequencer: full A/B runs, window edges, ADC timeout,
// trigger glitch rejection and reset in the middle of a servo pulse.
module tb_station_sequencer;

    logic        ACLK = 1'b0;
    logic        ARESET = 1'b1;
    logic        trigger = 1'b0;
    logic [11:0] digitalTemp = 12'd0;
    logic        ready = 1'b0;
    logic        adcRequest, correct, controlEM, controlServo, busy, fault;
    logic [3:0]  stationCount;

    int vectors = 0;
    int miscompares = 0;

    station_sequencer dut (
        .ACLK         (ACLK),
        .ARESET       (ARESET),
        .trigger      (trigger),
        .digitalTemp  (digitalTemp),
        .ready        (ready),
        .adcRequest   (adcRequest),
        .correct      (correct),
        .controlEM    (controlEM),
        .controlServo (controlServo),
        .busy         (busy),
        .fault        (fault),
        .stationCount (stationCount)
    );

    always #5 ACLK = ~ACLK;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge ACLK);
            #1;
        end
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One full A+B station cycle with hand-computed expectations.
    task automatic run_station(input int temp, input logic rdy, input int exp_ok,
                               input int exp_fault, input int exp_count);
        int n;
        int req_cyc;
        int servo_cyc;
        int em_bad;
        digitalTemp = 12'(temp);
        ready       = rdy;
        trigger     = 1'b1;
        n = 0;
        do begin
            tick(1);
            n++;
        end while (!adcRequest && n < 30);
        check($sformatf("req_latency t=%0d", temp), n, 6);
        req_cyc = 0;
        while (adcRequest && req_cyc < 20) begin
            req_cyc++;
            tick(1);
        end
        check($sformatf("req_cycles t=%0d", temp), req_cyc, rdy ? 1 : 8);
        tick(1);
        check($sformatf("correct t=%0d", temp), int'(correct), exp_ok);
        check($sformatf("em t=%0d", temp), int'(controlEM), exp_ok);
        check($sformatf("fault t=%0d", temp), int'(fault), exp_fault);
        tick(10);
        trigger = 1'b0;
        tick(15);
        check($sformatf("busy_wait_b t=%0d", temp), int'(busy), 1);
        check($sformatf("em_hold t=%0d", temp), int'(controlEM), exp_ok);
        trigger   = 1'b1;
        servo_cyc = 0;
        em_bad    = 0;
        for (int i = 0; i < 30; i++) begin
            tick(1);
            if (controlServo) begin
                servo_cyc++;
                if (controlEM) em_bad++;
            end
        end
        check($sformatf("servo_cycles t=%0d", temp), servo_cyc, exp_ok ? 10 : 0);
        check($sformatf("em_during_servo t=%0d", temp), em_bad, 0);
        trigger = 1'b0;
        tick(15);
        check($sformatf("station_count t=%0d", temp), int'(stationCount), exp_count);
        check($sformatf("busy_idle t=%0d", temp), int'(busy), 0);
        check($sformatf("correct_cleared t=%0d", temp), int'(correct), 0);
        $display("run temp=%0d ready=%0b servo=%0d count=%0d", temp, rdy, servo_cyc, stationCount);
    endtask

    initial begin
        int seen_req;
        tick(3);
        ARESET = 1'b0;
        check("reset_outputs",
              int'({adcRequest, correct, controlEM, controlServo, busy, fault}), 0);
        check("reset_count", int'(stationCount), 0);
        tick(5);

        run_station(1700, 1'b1, 1, 0, 1);
        run_station(1020, 1'b1, 0, 0, 2);
        run_station(2652, 1'b1, 0, 0, 3);
        run_station(1360, 1'b1, 1, 0, 4);
        run_station(1359, 1'b1, 0, 0, 5);
        run_station(2040, 1'b1, 1, 0, 6);
        run_station(2041, 1'b1, 0, 0, 7);
        run_station(1700, 1'b0, 0, 1, 8);

        // Two-cycle glitch must not start a run.
        trigger = 1'b1;
        tick(2);
        trigger  = 1'b0;
        seen_req = 0;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            if (adcRequest || busy) seen_req = 1;
        end
        check("glitch_rejected", seen_req, 0);
        $display("glitch 2 cycles busy_seen=%0d", seen_req);

        // Good run again (fault stays sticky), then reset on cycle 4 of the servo pulse.
        run_station(1700, 1'b1, 1, 1, 9);
        digitalTemp = 12'd1700;
        ready       = 1'b1;
        trigger     = 1'b1;
        tick(20);
        trigger = 1'b0;
        tick(15);
        trigger = 1'b1;
        seen_req = 0;
        while (!controlServo && seen_req < 30) begin
            tick(1);
            seen_req++;
        end
        check("servo_started", int'(controlServo), 1);
        tick(3);
        check("servo_cycle4", int'(controlServo), 1);
        ARESET  = 1'b1;
        trigger = 1'b0;
        tick(1);
        check("midservo_reset_outputs",
              int'({adcRequest, correct, controlEM, controlServo, busy, fault}), 0);
        check("midservo_reset_count", int'(stationCount), 0);
        ARESET = 1'b0;
        tick(12);
        check("post_reset_idle", int'(busy), 0);
        $display("reset mid-servo count=%0d busy=%0b", stationCount, busy);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/station_sequencer.md
Name: station_sequencer

Overview:
- Top-level sequencer for one material run. It detects stations from the line-sensor `trigger` and alternates between station A (temperature check) and station B (drop).
- At station A it runs one XADC read with a request/ready handshake and judges the temperature against a window. It then holds the material on the electromagnet until station B.
- At station B it releases the electromagnet and pulses the servo. It sits between the line follower, the XADC wrapper and the EM/servo drivers.

Parameters:
- DEBOUNCE_CYC, 3: consecutive stable synchronized cycles required to change the debounced trigger.
- SCALE, 68: XADC counts per degree C.
- TEMP_LO, 20: lower bound of the pass window in degrees C, inclusive.
- TEMP_HI, 30: upper bound of the pass window in degrees C, inclusive.
- SERVO_HOLD_CYC, 10: number of cycles `controlServo` stays high per drop.
- ADC_TIMEOUT_CYC, 8: maximum cycles to wait for `ready` after a request.

Ports:
- ACLK, input, 1: system clock.
- ARESET, input, 1: synchronous, active-high reset.
- trigger, input, 1: raw station-detect sensor; asynchronous to ACLK.
- digitalTemp, input, 12: XADC temperature code; valid while `ready` is high.
- ready, input, 1: XADC data-valid.
- adcRequest, output, 1: XADC conversion request.
- correct, output, 1: latched pass/fail of the last station-A sample.
- controlEM, output, 1: electromagnet enable.
- controlServo, output, 1: servo drop pulse.
- busy, output, 1: high in every state except WAIT_A.
- fault, output, 1: sticky ADC-timeout flag.
- stationCount, output, 4: count of completed A+B cycles; wraps 15 to 0.

Behaviour:
- Reset:
  - Applied only on an ACLK edge with ARESET=1.
  - Every output is 0 on the edge after reset.
  - State goes to WAIT_A; synchronizer, debounced trigger, counters and latched temperature all clear.
  - Reset mid-operation, including mid-servo pulse or mid-request, aborts at once with no completion pulse.
- Trigger conditioning:
  - 2-FF synchronizer feeds the debouncer.
  - The debounced trigger `trigDb` takes the synchronized value once that value has differed from `trigDb` for DEBOUNCE_CYC consecutive cycles.
  - Any shorter glitch resets the run counter.
  - A raw edge reaches `trigDb` in 2+DEBOUNCE_CYC cycles (5 with defaults).
- States:
  - WAIT_A: on `trigDb`=1, go to REQ.
  - REQ:
    - `adcRequest`=1 and a timeout counter runs.
    - If `ready`=1 in the same cycle, capture `digitalTemp` and go to JUDGE.
    - If the counter reaches ADC_TIMEOUT_CYC first, set `fault`=1 and `correct`=0, deassert the request and go to LEAVE_A.
    - `adcRequest` drops on the cycle after capture.
  - JUDGE: one cycle.
    - `correct` = (temp >= TEMP_LO*SCALE) && (temp <= TEMP_HI*SCALE), computed as unsigned 12-bit compares on 13-bit constants.
    - `controlEM` = `correct`. Both are registered outputs that update on exit from JUDGE.
    - Go to LEAVE_A.
  - LEAVE_A: wait for `trigDb`=0, then go to WAIT_B.
  - WAIT_B: on `trigDb`=1:
    - If `correct`=1: go to SERVO.
    - Else: go to LEAVE_B with no actuation.
  - SERVO:
    - `controlEM`=0 on entry.
    - `controlServo`=1 for exactly SERVO_HOLD_CYC cycles, then 0.
    - Go to LEAVE_B. Trigger changes during SERVO are ignored.
  - LEAVE_B: wait for `trigDb`=0, increment `stationCount`, clear `correct`, go to WAIT_A.
- Output persistence:
  - `correct` and `controlEM` persist from JUDGE until cleared in SERVO/LEAVE_B.
  - `controlServo` is never high outside SERVO.
  - `fault` stays set until ARESET; sequencing continues while it is set.
- If `trigger` is still high at reset release, WAIT_A sees `trigDb` rise after the debounce period and starts a run; this is intended.

Test Plan:
- digitalTemp=1700 (25 C), ready=1, trigger high for 50 cycles, low for 250, high for 50, low for 500 -> `adcRequest` 1 cycle; `correct`=1 and `controlEM`=1 after JUDGE; at station B `controlEM`=0 and `controlServo` high exactly 10 cycles; `stationCount`=1.
- digitalTemp=1020 (15 C), then 2652 (39 C), same trigger pattern -> `correct`=0, `controlEM` stays 0, `controlServo` never asserts; `stationCount` increments to 2 and 3.
- Window edges: 1360 -> `correct`=1; 1359 -> 0; 2040 -> 1; 2041 -> 0.
- ready held 0 during REQ -> `fault`=1 after 8 cycles, `adcRequest` deasserts, `correct`=0, and the sequence still advances through station B with no servo pulse.
- trigger glitch high for 2 cycles in WAIT_A -> no state change; high for 3+ cycles -> `adcRequest` rises 6 cycles after the raw edge.
- ARESET asserted on cycle 4 of a servo pulse -> next edge has all outputs 0, `stationCount`=0, state WAIT_A.
